// File: rtl/sn_stream_decoder.sv
// Stochastic-number stream decoder: counts the ones in a window of L valid
// bits (L = 8/16/32/64) and reports the count as the decoded value.
// Optional build macro SN_BIPOLAR_EN: result = 2*ones - L (two's complement)
// instead of the plain unsigned ones count.
module sn_stream_decoder #(
  parameter int unsigned RES_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sn_bit,
  input  logic             sn_valid,
  input  logic             start,
  input  logic [1:0]       win_sel,
  input  logic             cont,
  input  logic             result_ack,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       win_sel_q, win_sel_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       ones_cnt_q, ones_cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overrun_q, overrun_d;

  logic [6:0]       win_len;
  logic [6:0]       bit_cnt_inc;
  logic [6:0]       ones_cnt_inc;
  logic             last_bit;
  logic [RES_W-1:0] window_value;

  // Window length 8 << win_sel; counters are 7 bits so 64 fits without wrap.
  assign win_len      = 7'd8 << win_sel_q;
  assign bit_cnt_inc  = bit_cnt_q + 7'd1;
  assign ones_cnt_inc = ones_cnt_q + {6'd0, sn_bit};
  assign last_bit     = (bit_cnt_inc == win_len);

  // Decoded value of the window including the bit accepted this cycle.
`ifdef SN_BIPOLAR_EN
  assign window_value = (RES_W'(ones_cnt_inc) << 1) - RES_W'(win_len);
`else
  assign window_value = RES_W'(ones_cnt_inc);
`endif

  // Next-state, counter and result-handshake logic.
  always_comb begin
    state_d        = state_q;
    win_sel_d      = win_sel_q;
    bit_cnt_d      = bit_cnt_q;
    ones_cnt_d     = ones_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;

    // A completion in the same cycle overrides this clear below.
    if (result_ack) begin
      result_valid_d = 1'b0;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          win_sel_d  = win_sel;
          bit_cnt_d  = 7'd0;
          ones_cnt_d = 7'd0;
          overrun_d  = 1'b0;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        // start wins over a bit arriving in the same cycle, even a completing one.
        if (start) begin
          win_sel_d  = win_sel;
          bit_cnt_d  = 7'd0;
          ones_cnt_d = 7'd0;
          overrun_d  = 1'b0;
        end else if (sn_valid) begin
          if (last_bit) begin
            result_d       = window_value;
            result_valid_d = 1'b1;
            if (result_valid_q && !result_ack) begin
              overrun_d = 1'b1;
            end
            bit_cnt_d  = 7'd0;
            ones_cnt_d = 7'd0;
            state_d    = cont ? StAccum : StDone;
          end else begin
            bit_cnt_d  = bit_cnt_inc;
            ones_cnt_d = ones_cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; rst_n is an active-high asynchronous reset here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q        <= StIdle;
      win_sel_q      <= 2'b00;
      bit_cnt_q      <= 7'd0;
      ones_cnt_q     <= 7'd0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      win_sel_q      <= win_sel_d;
      bit_cnt_q      <= bit_cnt_d;
      ones_cnt_q     <= ones_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q == StAccum);
  assign overrun      = overrun_q;

endmodule

// File: doc/sn_stream_decoder.md
SN_STREAM_DECODER -- requirements
Module: sn_stream_decoder

Interface
REQ-001 SHALL have parameter RES_W, default 8, width of result; legal values 8 only, with other values unsupported.
REQ-002 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port sn_bit, input, 1, serial stochastic bit, sampled only when sn_valid=1.
REQ-005 SHALL have port sn_valid, input, 1, qualifies sn_bit this cycle.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that arms or re-arms a window.
REQ-007 SHALL have port win_sel, input, 2, window length L: 00=8, 01=16, 10=32, 11=64 bits; latched on start.
REQ-008 SHALL have port cont, input, 1, continuous mode; sampled at each window completion.
REQ-009 SHALL have port result_ack, input, 1, consumer acknowledge of result.
REQ-010 SHALL have port result, output, RES_W, decoded value of last completed window.
REQ-011 SHALL have port result_valid, output, 1, result unread.
REQ-012 SHALL have port busy, output, 1, high in ACCUM state.
REQ-013 SHALL have port overrun, output, 1, sticky: a result was overwritten while unread.

Function
REQ-014 SHALL implement states IDLE, ACCUM, DONE; busy=1 only in ACCUM.
REQ-015 IDLE/DONE: start=1 -> latch win_sel, clear bit_cnt and ones_cnt, clear overrun, go ACCUM next cycle.
REQ-016 ACCUM: each cycle with sn_valid=1 -> bit_cnt+1, ones_cnt+sn_bit; cycles with sn_valid=0 change nothing.
REQ-017 Completion: the cycle accepting the L-th valid bit SHALL load result (including that bit) and set result_valid on the following edge; latency 1 cycle from last bit to result_valid.
REQ-018 At completion, cont=1 -> stay ACCUM with counters cleared, so the next valid bit (even on the very next cycle) counts as bit 1 of a new window; no bit dropped.
REQ-019 At completion, cont=0 -> go DONE; sn_bit ignored until next start.
REQ-020 start during ACCUM SHALL abort the current window, discard partial counts, relatch win_sel, restart; result/result_valid unchanged.
REQ-021 result_ack=1 SHALL clear result_valid next edge; result holds its value.
REQ-022 Completion with result_valid=1 and result_ack=0 SHALL overwrite result and set overrun.
REQ-023 Completion coincident with result_ack=1 SHALL load the new result, keep result_valid=1, not set overrun.
REQ-024 ones_cnt SHALL be 7 bits (0..64), never wrap; result unsigned value = ones_cnt zero-extended to RES_W.
REQ-025 start coincident with a completing bit SHALL take priority: no result load, window restarts.

Reset
REQ-026 rst_n=1 SHALL immediately force state IDLE, result=0, result_valid=0, busy=0, overrun=0, counters=0, latched L=8.
REQ-027 Reset mid-window SHALL discard the partial window; no result produced on release.

Configuration
REQ-028 Macro SN_BIPOLAR_EN defined -> result = 2*ones_cnt - L as RES_W-bit two's complement (range -64..+64).
REQ-029 SN_BIPOLAR_EN undefined -> result = unsigned ones_cnt per REQ-024; all else identical.

Verification
REQ-030 start, win_sel=00, 8 valid bits 1,0,1,1,0,0,1,0 -> result=4 (bipolar 0), result_valid=1 one cycle after bit 8, state DONE.
REQ-031 win_sel=11, cont=1, 64 ones then 64 zeros back-to-back, ack after each -> results 64 then 0 (bipolar +64, -64), overrun=0.
REQ-032 win_sel=00, cont=1, no ack over two windows of all ones -> second completion sets overrun=1, result=8; ack on exactly the second completion cycle instead -> overrun=0.
REQ-033 win_sel=01, sn_valid toggling 1/0 for 32 cycles -> completion after 16th valid bit only; start after bit 10 -> no result, window restarts from 0.
REQ-034 rst_n pulse mid-ACCUM after 5 bits -> all outputs 0 immediately, IDLE; subsequent bits ignored until start.
